// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared constants and helpers for the digit scan controller.
// Provides digit count, nibble width, first select, full brightness, nibble pick and leading-zero test.
package digit_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int NIBBLE_W   = 4;
   localparam logic [NUM_DIGITS-1:0] SEL_FIRST   = 4'b1000;
   localparam logic [NIBBLE_W-1:0]   BRIGHT_FULL = 4'hF;

   function automatic logic [NIBBLE_W-1:0] pick_nibble(
      input logic [15:0] w,
      input logic [NUM_DIGITS-1:0] sel
   );
      logic [NIBBLE_W-1:0] r;
      r = '0;
      unique case (1'b1)
         sel[3]: r = w[15:12];
         sel[2]: r = w[11:8];
         sel[1]: r = w[7:4];
         sel[0]: r = w[3:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   // Digit k is a leading zero when every nibble from k upward is zero.
   // Digit 0 always shows, so an all-zero word still displays "0".
   function automatic logic lead_zero(
      input logic [15:0] w,
      input logic [NUM_DIGITS-1:0] sel
   );
      logic r;
      r = 1'b0;
      unique case (1'b1)
         sel[3]: r = (w[15:12] == 4'h0);
         sel[2]: r = (w[15:8] == 8'h00);
         sel[1]: r = (w[15:4] == 12'h000);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst (sync, active high) in; tick out (high when count == TICK_DIV-1).
module tick_gen #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [15:0] ps_cnt_q;
   logic [15:0] ps_cnt_d;

   assign tick     = (ps_cnt_q == 16'(TICK_DIV - 1));
   assign ps_cnt_d = tick ? 16'd0 : ps_cnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) ps_cnt_q <= '0;
      else     ps_cnt_q <= ps_cnt_d;
   end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit seven-segment scan with frame-aligned double buffer and PWM.
// Inputs: clk, rst, data_in[15:0], data_valid, bright[3:0].
// Outputs: data_ready, sel[3:0], value[3:0], digit_en, blank, frame_start.
// Define DIGIT_SCAN_LZB_EN to enable leading-zero blanking; otherwise blank is 0.
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [NIBBLE_W-1:0]   bright,
   output logic [NUM_DIGITS-1:0] sel,
   output logic [NIBBLE_W-1:0]   value,
   output logic                  digit_en,
   output logic                  blank,
   output logic                  frame_start
);

   logic                  tick;
   logic                  boundary;
   logic                  accept;
   logic                  pwm_on;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [NIBBLE_W-1:0]   value_q, value_d;
   logic [15:0]           shadow_q, shadow_d;
   logic [15:0]           pend_q, pend_d;
   logic                  pend_full_q, pend_full_d;
   logic [3:0]            duty_q;
   logic                  en_q, en_d;
   logic                  fs_q;
   logic                  blank_d;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign boundary = tick && (sel_q == 4'b0001);
   assign accept   = data_valid && !pend_full_q;
   assign pwm_on   = (bright == BRIGHT_FULL) || (duty_q < bright);

   always_comb begin
      sel_d       = sel_q;
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      if (tick) sel_d = {sel_q[0], sel_q[3:1]};
      // A queued word wins the boundary; an accept on that same
      // cycle can only bypass into shadow when nothing is queued.
      if (boundary && pend_full_q) begin
         shadow_d    = pend_q;
         pend_full_d = 1'b0;
      end else if (boundary && accept) begin
         shadow_d = data_in;
      end else if (accept) begin
         pend_d      = data_in;
         pend_full_d = 1'b1;
      end
      // Use the next shadow so a boundary load shows on digit 3 at once.
      value_d = tick ? pick_nibble(shadow_d, sel_d) : value_q;
   end

`ifdef DIGIT_SCAN_LZB_EN
   logic blank_q;

   always_comb begin
      blank_d = tick ? lead_zero(shadow_d, sel_d) : blank_q;
   end

   always_ff @(posedge clk) begin
      if (rst) blank_q <= 1'b0;
      else     blank_q <= blank_d;
   end

   assign blank = blank_q;
`else
   assign blank_d = 1'b0;
   assign blank   = 1'b0;
`endif

   assign en_d = pwm_on && !blank_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q       <= SEL_FIRST;
         value_q     <= '0;
         shadow_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         duty_q      <= '0;
         en_q        <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         value_q     <= value_d;
         shadow_q    <= shadow_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         duty_q      <= duty_q + 4'd1;
         en_q        <= en_d;
         fs_q        <= boundary;
      end
   end

   assign data_ready  = !pend_full_q;
   assign sel         = sel_q;
   assign value       = value_q;
   assign digit_en    = en_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: vector table, corner sequences and random run against a model.
// The model derives state from the edge count since reset and the word buffer rules.
module tb_digit_scan_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [3:0]  bright = 4'hF;
   logic [3:0]  sel;
   logic [3:0]  value;
   logic        digit_en;
   logic        blank;
   logic        frame_start;

   int nvec = 0;
   int nerr = 0;

   // model state
   int          n = 0;
   logic [15:0] sh_m = '0;
   logic [15:0] pend_m = '0;
   logic        pf_m = 1'b0;
   logic [3:0]  e_sel;
   logic [3:0]  e_val;
   logic        e_fs;
   logic        e_en;
   logic        e_blank;

   always #5 clk = ~clk;

   digit_scan_ctrl #(.TICK_DIV(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .bright      (bright),
      .sel         (sel),
      .value       (value),
      .digit_en    (digit_en),
      .blank       (blank),
      .frame_start (frame_start)
   );

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at edge %0d: got %h want %h", name, n, act, exp);
      end
   endtask

   function automatic logic lz(input logic [15:0] w, input int d);
`ifdef DIGIT_SCAN_LZB_EN
      if (d == 0) return 1'b0;
      return ((w >> (4 * d)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic step(input logic v, input logic [15:0] d, input logic [3:0] b);
      logic acc;
      int   dig;
      data_valid = v;
      data_in    = d;
      bright     = b;
      @(posedge clk);
      acc = v && !pf_m;
      n++;
      if (n % (4 * T) == 0) begin
         if (pf_m) begin
            sh_m = pend_m;
            pf_m = 1'b0;
         end else if (acc) begin
            sh_m = d;
         end
      end else if (acc) begin
         pend_m = d;
         pf_m   = 1'b1;
      end
      dig     = 3 - ((n / T) % 4);
      e_sel   = 4'(1 << dig);
      e_val   = sh_m[4*dig +: 4];
      e_fs    = (n % (4 * T) == 0);
      e_blank = lz(sh_m, dig);
      e_en    = ((b == 4'hF) || (((n - 1) % 16) < int'(b))) && !e_blank;
      #1;
   endtask

   task automatic check_model();
      check("sel", 16'(sel), 16'(e_sel));
      check("value", 16'(value), 16'(e_val));
      check("ready", 16'(data_ready), 16'(!pf_m));
      check("frame_start", 16'(frame_start), 16'(e_fs));
      check("digit_en", 16'(digit_en), 16'(e_en));
      check("blank", 16'(blank), 16'(e_blank));
   endtask

   task automatic do_reset(input int cyc);
      rst = 1'b1;
      data_valid = 1'b0;
      repeat (cyc) @(posedge clk);
      #1;
      check("rst_sel", 16'(sel), 16'h8);
      check("rst_value", 16'(value), 16'h0);
      check("rst_ready", 16'(data_ready), 16'h1);
      check("rst_en", 16'(digit_en), 16'h0);
      check("rst_fs", 16'(frame_start), 16'h0);
      check("rst_blank", 16'(blank), 16'h0);
      rst  = 1'b0;
      n    = 0;
      sh_m = '0;
      pf_m = 1'b0;
   endtask

   task automatic run_to_boundary(input logic [3:0] b);
      for (int i = 0; i < 4 * T && (n % (4 * T)) != 0; i++) begin
         step(1'b0, 16'h0, b);
         check_model();
      end
   endtask

`ifdef DIGIT_SCAN_LZB_EN
   task automatic lzb_frame(input logic [15:0] w, input logic [3:0] bl,
                            input logic [3:0] en);
      step(1'b1, w, 4'hF);
      check_model();
      run_to_boundary(4'hF);
      for (int d = 3; d >= 0; d--) begin
         check("lzb_blank", 16'(blank), 16'(bl[d]));
         check("lzb_en", 16'(digit_en), 16'(en[d]));
         check("lzb_value", 16'(value), 16'(w[4*d +: 4]));
         if (d > 0) repeat (T) step(1'b0, 16'h0, 4'hF);
      end
   endtask
`endif

   typedef struct {
      logic        v;
      logic [15:0] d;
      int          len;
      logic [3:0]  sel;
      logic [3:0]  val;
      logic        rdy;
      logic        fs;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int cnt;
      logic [3:0] br;
      logic [3:0] bl3;
      bl3 = 4'h3;

      tbl[0]  = '{1'b0, 16'h0000, 4,  4'b0100, 4'h0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 16'h1234, 1,  4'b0100, 4'h0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 10, 4'b0001, 4'h0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1,  4'b1000, 4'h1, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 16'h0000, 1,  4'b1000, 4'h1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 3,  4'b0100, 4'h2, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 4,  4'b0010, 4'h3, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 4,  4'b0001, 4'h4, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 16'hAAAA, 1,  4'b0001, 4'h4, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 16'hBBBB, 3,  4'b1000, 4'hA, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 16'hBBBB, 1,  4'b1000, 4'hA, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'h0000, 15, 4'b1000, 4'hB, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 16'h0000, 15, 4'b0001, 4'hB, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 16'h5678, 1,  4'b1000, 4'h5, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 16'h0000, 4,  4'b0100, 4'h6, 1'b1, 1'b0};

      @(posedge clk);
      do_reset(3);

      for (int r = 0; r < 15; r++) begin
         for (int j = 0; j < tbl[r].len; j++) begin
            step(tbl[r].v, tbl[r].d, 4'hF);
            check_model();
         end
         check("tbl_sel", 16'(sel), 16'(tbl[r].sel));
         check("tbl_value", 16'(value), 16'(tbl[r].val));
         check("tbl_ready", 16'(data_ready), 16'(tbl[r].rdy));
         check("tbl_fs", 16'(frame_start), 16'(tbl[r].fs));
      end

      // PWM: shadow holds 5678, so no digit is blanked
      for (int k = 0; k < 3; k++) begin
         br = (k == 0) ? 4'd0 : (k == 1) ? 4'd8 : 4'd15;
         step(1'b0, 16'h0, br);
         cnt = 0;
         for (int j = 0; j < 16; j++) begin
            step(1'b0, 16'h0, br);
            check_model();
            cnt += int'(digit_en);
         end
         check("pwm_count", 16'(cnt), (k == 0) ? 16'd0 : (k == 1) ? 16'd8 : 16'd16);
      end

`ifdef DIGIT_SCAN_LZB_EN
      lzb_frame(16'h0050, 4'b1100, bl3);
      lzb_frame(16'h0000, 4'b1110, 4'b0001);
`endif

      // reset mid-frame while a word is pending
      if (((n + 1) % (4 * T)) == 0) step(1'b0, 16'h0, 4'hF);
      step(1'b1, 16'hCAFE, 4'hF);
      check_model();
      check("pend_ready", 16'(data_ready), 16'h0);
      do_reset(2);
      for (int j = 0; j < 5 * T; j++) begin
         step(1'b0, 16'h0, 4'hF);
         check_model();
      end
      check("post_rst_value", 16'(value), 16'h0);
      check("post_rst_ready", 16'(data_ready), 16'h1);

      // random run
      do_reset(1);
      br = 4'hF;
      for (int j = 0; j < 800; j++) begin
         if (j % 32 == 0) br = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 2) == 0), 16'($urandom), br);
         check_model();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Scan controller for the 4-digit seven-segment display on the IO shield. It accepts a 16-bit hex word through a valid/ready handshake and double-buffers it so updates only take effect at frame boundaries. It cycles a one-hot digit select, emits the matching nibble, and gates each digit with a brightness PWM and optional leading-zero blanking. It sits between the application logic and the nibble-to-segment decode and drive logic.

## Interface
- `TICK_DIV`, 50000: clk cycles per digit slot; legal range 2..65535 (50 MHz clock gives a 1 kHz slot rate).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  16  four hex nibbles; `[15:12]` is digit 3 (leftmost).
- `data_valid`  in  1  `data_in` is offered this cycle.
- `data_ready`  out  1  pending buffer empty; a word is accepted when `data_valid && data_ready`.
- `bright`  in  4  brightness level; 0 = off, 15 = full.
- `sel`  out  4  one-hot digit select; 4'b1000 means digit 3.
- `value`  out  4  nibble for the digit named by `sel`.
- `digit_en`  out  1  drive enable for the current digit (PWM and blank gated).
- `blank`  out  1  current digit is suppressed by leading-zero blanking.
- `frame_start`  out  1  one-cycle pulse when `sel` wraps to 4'b1000.

## Operation
- **Prescaler.** `ps_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is asserted when `ps_cnt == TICK_DIV-1`.
- **Scan ring.** On `tick`, `sel` rotates right: 1000→0100→0010→0001→1000. `value` is updated in the same edge with `shadow[4*k+3 -: 4]` for the new digit k.
- **Frame boundary.** A boundary is a `tick` while `sel == 4'b0001`. At a boundary `frame_start` is pulsed, and the shadow register is loaded only if new data exists, in this priority order:
  - If `pend_full`, `shadow <= pend` and `pend_full` clears.
  - Else, if a handshake occurs in the same cycle, `shadow <= data_in` directly (bypass) and `pend_full` stays 0.
- **Handshake.** `data_ready = !pend_full`, driven straight from the flop. An accepted word outside the bypass case loads `pend` and sets `pend_full`. The new word never reaches `shadow` mid-frame, so a frame always shows one consistent word.
- **PWM.** `duty_cnt` is a 4-bit counter that runs freely every cycle.
  - `pwm_on = (bright == 15) || (duty_cnt < bright)`.
  - Duty cycle: 0 gives 0, 1..14 gives bright/16, 15 gives 100%.
- **Enable.** `digit_en` is registered: `digit_en <= pwm_on && !blank_next`.
- **Reset values.** `sel` = 4'b1000, `value` = 0, `shadow` = 0, `pend_full` = 0 (so `data_ready` = 1), `ps_cnt` = 0, `duty_cnt` = 0, `digit_en` = 0, `blank` = 0, `frame_start` = 0.
- **Reset mid-operation.** Any pending word is discarded and the display restarts at digit 3 showing 0.
- `bright` is sampled every cycle; a change takes effect within one cycle.

## Timing
- `sel`, `value` and `blank` change together on the `tick` edge and are aligned cycle for cycle.
- `digit_en` is aligned with `sel`: it is registered from the same-cycle `sel_next` and `blank_next`.
- Each digit is held for exactly TICK_DIV cycles; a full frame is 4·TICK_DIV cycles.
- First `frame_start` after reset occurs 4·TICK_DIV cycles after reset deasserts; it is not pulsed on reset.
- Latency from accept to display:
  - Minimum: 1 cycle, when the accept is a bypass at a boundary.
  - Maximum: 4·TICK_DIV cycles.
- `data_ready` stays low from an accept until the next boundary edge, then returns high on the following cycle.

## Configuration
- **`DIGIT_SCAN_LZB_EN` defined.** `blank` is high for digit k ∈ {3,2,1} when `shadow[15:4k]` == 0. Digit 0 is never blanked, and a blanked digit forces `digit_en` = 0.
- **`DIGIT_SCAN_LZB_EN` undefined.** `blank` is tied to 0 and no blanking logic is synthesized.

## Structure
- Shared package `digit_scan_pkg` holds:
  - `NUM_DIGITS` = 4
  - `SEL_FIRST` = 4'b1000
  - `BRIGHT_FULL` = 4'hF
  - `NIBBLE_W` = 4
- One sub-module, `tick_gen`: a parameterized prescaler with `TICK_DIV` and `rst`, outputting a one-cycle `tick`. The rest is flat in `digit_scan_ctrl`.

## Test plan
All scenarios use TICK_DIV = 4.
- **Reset.** Assert `rst` 3 cycles. Expect `sel` = 1000, `value` = 0, `data_ready` = 1, `digit_en` = 0; first `frame_start` at cycle 16 after release.
- **Frame-aligned update.** Accept 16'h1234 at cycle 5. Expect `value` = 0 until the next boundary, then 1, 2, 3, 4 for 4 cycles each, with `sel` = 1000/0100/0010/0001.
- **Back-pressure.** Accept 16'hAAAA, then hold `data_valid` with 16'hBBBB. Expect `data_ready` = 0 until the boundary; BBBB is accepted the cycle after the boundary and shown one frame later.
- **Bypass.** Pulse `data_valid` with 16'h5678 exactly on the boundary cycle, pending empty. Expect digit 3 shows 5 on the next edge and `data_ready` stays 1.
- **PWM.** With `bright` = 0, 8 and 15, count `digit_en` highs over 16 aligned cycles. Expect 0, 8 and 16.
- **LZB (macro on).** Load 16'h0050: `blank` is 1 on digits 3 and 2, digit 1 shows 5 enabled, digit 0 shows 0 enabled. Load 16'h0000: only digit 0 is enabled. Assert `rst` mid-frame with a pending word: the display returns to 0 and the pending word is never shown.
